// File: rtl/iq_classify.sv
// rtl/iq_classify.sv - linear-boundary IQ readout classifier, 4-stage pipeline
module iq_classify (
    input  logic               clk100,
    input  logic               reset,
    input  logic               data_in,
    input  logic signed [31:0] i_val,
    input  logic signed [31:0] q_val,
    input  logic signed [31:0] i_pt_line,
    input  logic signed [31:0] q_pt_line,
    input  logic signed [31:0] i_vec_perp,
    input  logic signed [31:0] q_vec_perp,
    output logic [1:0]         state,
    output logic               valid_output
);

    localparam logic [1:0] ST_GROUND   = 2'b00;
    localparam logic [1:0] ST_EXCITED  = 2'b01;
    localparam logic [1:0] ST_BOUNDARY = 2'b10;

    // Stage 1: sample offsets from the line point, plus the normal captured alongside
    logic               s1_valid;
    logic signed [32:0] s1_di;
    logic signed [32:0] s1_dq;
    logic signed [31:0] s1_vi;
    logic signed [31:0] s1_vq;

    // Stage 2: projections of each offset onto the normal
    logic               s2_valid;
    logic signed [65:0] s2_pi;
    logic signed [65:0] s2_pq;

    // Stage 3: full-precision decision metric
    logic               s3_valid;
    logic signed [66:0] s3_sum;

    // Combinational operands, all sign-extended so plain modular add/multiply is exact
    logic [32:0] diff_i;
    logic [32:0] diff_q;
    logic [65:0] ext_di;
    logic [65:0] ext_dq;
    logic [65:0] ext_vi;
    logic [65:0] ext_vq;
    logic [66:0] sum_next;
    logic [1:0]  decode;

    // Operand widening and final sign/zero decode
    always_comb begin
        diff_i   = {i_val[31], i_val} - {i_pt_line[31], i_pt_line};
        diff_q   = {q_val[31], q_val} - {q_pt_line[31], q_pt_line};
        ext_di   = {{33{s1_di[32]}}, s1_di};
        ext_dq   = {{33{s1_dq[32]}}, s1_dq};
        ext_vi   = {{34{s1_vi[31]}}, s1_vi};
        ext_vq   = {{34{s1_vq[31]}}, s1_vq};
        sum_next = {s2_pi[65], s2_pi} + {s2_pq[65], s2_pq};
        if (s3_sum[66]) begin
            decode = ST_GROUND;
        end else if (s3_sum == '0) begin
            decode = ST_BOUNDARY;
        end else begin
            decode = ST_EXCITED;
        end
    end

    // Stage 1 capture: boundary inputs are latched with the sample so later edits do not disturb it
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_di    <= '0;
            s1_dq    <= '0;
            s1_vi    <= '0;
            s1_vq    <= '0;
        end else begin
            s1_valid <= data_in;
            if (data_in) begin
                s1_di <= diff_i;
                s1_dq <= diff_q;
                s1_vi <= i_vec_perp;
                s1_vq <= q_vec_perp;
            end
        end
    end

    // Stage 2 products; low 66 bits of the widened product equal the exact signed product
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_pi    <= '0;
            s2_pq    <= '0;
        end else begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_pi <= ext_di * ext_vi;
                s2_pq <= ext_dq * ext_vq;
            end
        end
    end

    // Stage 3 sum of projections
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            s3_valid <= 1'b0;
            s3_sum   <= '0;
        end else begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                s3_sum <= sum_next;
            end
        end
    end

    // Output register: state holds between results, valid pulses once per sample
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state        <= ST_GROUND;
            valid_output <= 1'b0;
        end else begin
            valid_output <= s3_valid;
            if (s3_valid) begin
                state <= decode;
            end
        end
    end

endmodule

// File: tb/tb_iq_classify.sv
// tb/tb_iq_classify.sv - scoreboard bench for iq_classify with randomized stimulus
module tb_iq_classify;

    logic               clk100 = 1'b0;
    logic               reset  = 1'b1;
    logic               data_in = 1'b0;
    logic signed [31:0] i_val = '0;
    logic signed [31:0] q_val = '0;
    logic signed [31:0] i_pt_line = '0;
    logic signed [31:0] q_pt_line = '0;
    logic signed [31:0] i_vec_perp = '0;
    logic signed [31:0] q_vec_perp = '0;
    logic [1:0]         state;
    logic               valid_output;

    typedef struct {
        logic [1:0] st;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    iq_classify dut (
        .clk100       (clk100),
        .reset        (reset),
        .data_in      (data_in),
        .i_val        (i_val),
        .q_val        (q_val),
        .i_pt_line    (i_pt_line),
        .q_pt_line    (q_pt_line),
        .i_vec_perp   (i_vec_perp),
        .q_vec_perp   (q_vec_perp),
        .state        (state),
        .valid_output (valid_output)
    );

    always #5 clk100 = ~clk100;

    always @(posedge clk100) cyc <= cyc + 1;

    // Reference: exact metric in wide arithmetic, classified by sign
    function automatic logic [1:0] ref_class(input logic signed [31:0] i, input logic signed [31:0] q,
                                             input logic signed [31:0] pi, input logic signed [31:0] pq,
                                             input logic signed [31:0] vi, input logic signed [31:0] vq);
        logic signed [127:0] a, b, c, d, e, f, m;
        a = i; b = q; c = pi; d = pq; e = vi; f = vq;
        m = (a - c) * e + (b - d) * f;
        if (m < 0) return 2'b00;
        else if (m > 0) return 2'b01;
        else return 2'b10;
    endfunction

    // Monitor: every valid pulse must match the oldest expected result and its cycle
    always @(negedge clk100) begin
        if (!reset && valid_output) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_valid cyc=%0d state=%b required no pulse", cyc, state);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (state !== e.st || cyc != e.cyc) begin
                    fails++;
                    $display("FAIL result state=%b cyc=%0d required state=%b cyc=%0d", state, cyc, e.st, e.cyc);
                end
            end
        end
    end

    task automatic send(input logic signed [31:0] i, input logic signed [31:0] q);
        exp_t e;
        i_val   = i;
        q_val   = q;
        data_in = 1'b1;
        e.st  = ref_class(i, q, i_pt_line, q_pt_line, i_vec_perp, q_vec_perp);
        e.cyc = cyc + 4;
        exp_q.push_back(e);
        @(posedge clk100); #1;
        data_in = 1'b0;
    endtask

    task automatic idle(input int n);
        data_in = 1'b0;
        repeat (n) begin
            @(posedge clk100); #1;
        end
    endtask

    task automatic set_bnd(input logic signed [31:0] pi, input logic signed [31:0] pq,
                           input logic signed [31:0] vi, input logic signed [31:0] vq);
        i_pt_line  = pi;
        q_pt_line  = pq;
        i_vec_perp = vi;
        q_vec_perp = vq;
    endtask

    task automatic check_out(input string name, input logic [1:0] st);
        tests++;
        if (state !== st || valid_output !== 1'b0) begin
            fails++;
            $display("FAIL %s state=%b valid=%b required state=%b valid=0", name, state, valid_output, st);
        end
    endtask

    task automatic check_drained(input string name);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s pending=%0d required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    function automatic logic signed [31:0] rand_val();
        int mode;
        mode = $urandom_range(0, 3);
        case (mode)
            0: return $urandom;
            1: return 32'h8000_0000 + $urandom_range(0, 2);
            2: return 32'h7FFF_FFFF - $urandom_range(0, 2);
            default: return 32'($urandom_range(0, 8)) - 32'sd4;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk100);
        #1;
        check_out("reset_state", 2'b00);
        reset = 1'b0;

        // Boundary sweep along q with a horizontal line at q=2
        set_bnd(0, 2, 0, 1);
        for (int k = -3; k <= 5; k++) begin
            send(k, k);
            idle(1);
        end
        idle(5);
        check_drained("sweep_drain");

        // Back-to-back samples
        send(0, 5);
        send(0, -5);
        send(0, 2);
        idle(5);
        check_drained("b2b_drain");

        // Extreme operands in both normal directions
        set_bnd(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);
        send(32'h8000_0000, 32'h8000_0000);
        set_bnd(32'h7FFF_FFFF, 32'h7FFF_FFFF, -32'sh7FFF_FFFF, 0);
        send(32'h8000_0000, 32'h8000_0000);
        idle(5);
        check_drained("extreme_drain");

        // Diagonal boundary
        set_bnd(0, 0, 1, -1);
        send(3, 1);
        send(1, 3);
        send(4, 4);
        idle(5);
        check_drained("diag_drain");

        // Reset mid-flight discards the in-flight sample; strobes during reset are ignored
        set_bnd(0, 2, 0, 1);
        send(0, 5);
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_out("reset_async", 2'b00);
        data_in = 1'b1;
        @(posedge clk100); #1;
        @(posedge clk100); #1;
        data_in = 1'b0;
        reset = 1'b0;
        idle(5);
        check_out("post_reset_state", 2'b00);
        send(0, 5);
        idle(5);
        check_drained("post_reset_drain");

        // Idle hold after an excited result
        for (int n = 0; n < 20; n++) begin
            @(posedge clk100); #1;
            check_out("idle_hold", 2'b01);
        end

        // Randomized traffic with occasional boundary changes
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                set_bnd(rand_val(), rand_val(), rand_val(), rand_val());
            end
            if ($urandom_range(0, 3) != 0) begin
                send(rand_val(), rand_val());
            end else begin
                idle(1);
            end
        end
        idle(6);
        check_drained("random_drain");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/iq_classify.md
# iq_classify

Single-shot qubit readout classifier for the FPGA readout chain. Each demodulated IQ sample (`i_val`, `q_val`) arriving with a `data_in` strobe is compared against a linear decision boundary. The boundary is given as a point on the line plus a vector perpendicular to it. The block emits a 2-bit state code with a one-cycle valid pulse, and downstream histogram/statistics logic consumes it.

## Interface
Parameters:
- none; all widths fixed at 32-bit signed inputs.

Ports (one clock; reset is asynchronous and active-high):
- `clk100`  in  1  system clock, 100 MHz domain, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `data_in`  in  1  sample strobe; each rising `clk100` edge with `data_in`=1 captures one sample
- `i_val`  in  32 signed  in-phase sample
- `q_val`  in  32 signed  quadrature sample
- `i_pt_line`  in  32 signed  I coordinate of a point on the decision line
- `q_pt_line`  in  32 signed  Q coordinate of a point on the decision line
- `i_vec_perp`  in  32 signed  I component of the line normal (points toward state 1)
- `q_vec_perp`  in  32 signed  Q component of the line normal
- `state`  out  2  classification result, held between results
- `valid_output`  out  1  one-cycle pulse marking a new `state`

## Operation
- Decision metric: d = (i_val − i_pt_line)·i_vec_perp + (q_val − q_pt_line)·q_vec_perp.
- State encoding:
  - d < 0 → `state`=2'b00 (ground)
  - d > 0 → `state`=2'b01 (excited)
  - d = 0 → `state`=2'b10 (on boundary)
  - 2'b11 is never produced.
- Arithmetic is full precision, so no overflow or saturation can occur:
  - differences: 33-bit signed
  - products: 66-bit signed
  - sum: 67-bit signed
- Pipeline, one valid bit per stage:
  - S1 registers the two differences, sampled together with the boundary inputs when `data_in`=1.
  - S2 registers the two products.
  - S3 registers the sum.
  - The output register decodes the sign/zero of the sum.
- Boundary inputs (`*_pt_line`, `*_vec_perp`) are sampled in S1 with the data, so changing them affects only later samples.
- Back-to-back samples (`data_in` high on consecutive edges) are each classified. Throughput is 1 sample per cycle, with no stalls and no backpressure.
- No edge detection: a strobe held high for N edges yields N classifications.
- `state` holds its last value until the next result; `valid_output` is 0 otherwise.

## Timing
- Latency:
  - sample captured at edge T → `state` updated and `valid_output`=1 after edge T+3
  - `valid_output` is high for exactly one cycle per sample.
- Reset (async assert, released synchronously by the environment):
  - `state`=2'b00, `valid_output`=0, all pipeline valid bits cleared
  - in-flight samples are discarded; no valid pulse is produced for them after release
  - first sample accepted on the first rising edge with `reset`=0.
- `data_in` asserted during reset is ignored.
- If `data_in` is high coincident with a result leaving the pipeline, both proceed independently.

## Test plan
- Boundary sweep: pt_line=(0,2), perp=(0,1); pulse `data_in` every other cycle with i=q=−3,−2,…,5.
  - Required: q<2 gives 2'b00, q=2 gives 2'b10, q>2 gives 2'b01.
  - Each result appears 3 cycles after its strobe with a single-cycle `valid_output`.
- Back-to-back: samples (0,5),(0,−5),(0,2) on consecutive edges, same boundary.
  - Required: `valid_output` high for 3 consecutive cycles with `state` 01, 00, 10.
- Extreme values: i=q=32'h8000_0000, pt_line=(32'h7FFF_FFFF,32'h7FFF_FFFF), perp=(32'h7FFF_FFFF,0).
  - Required: d<0, so `state`=00 with no overflow.
  - Negating perp gives `state`=01.
- Diagonal boundary: pt_line=(0,0), perp=(1,−1).
  - Required: (3,1)→01, (1,3)→00, (4,4)→10.
- Reset mid-flight: strobe (0,5), assert `reset` one cycle later, release it two cycles later.
  - Required: no `valid_output` pulse, `state`=00.
  - Next sample (0,5) gives 01 after 3 cycles.
- Idle hold: after a result of 01, keep `data_in`=0 for 20 cycles.
  - Required: `state` stays 01 and `valid_output` stays 0.
